// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: funct3 access types, FSM states
// and access-size decode.
package dmem_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // Access size in bytes; illegal encodings report 1 so range math stays well-defined.
  function automatic logic [2:0] access_size(input logic [2:0] funct3);
    unique case (funct3)
      Funct3H, Funct3Hu: access_size = 3'd2;
      Funct3W:           access_size = 3'd4;
      default:           access_size = 3'd1;
    endcase
  endfunction

  // Unsigned variants only make sense for loads.
  function automatic logic funct3_legal(input logic [2:0] funct3, input logic write);
    unique case (funct3)
      Funct3B, Funct3H, Funct3W: funct3_legal = 1'b1;
      Funct3Bu, Funct3Hu:        funct3_legal = ~write;
      default:                   funct3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with per-byte-lane write enables and combinational read.
module dmem_array #(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam int unsigned Depth = MEM_BYTES / 4;

  // Not reset: contents survive rst_n and start at zero in simulation.
  logic [31:0] mem [Depth] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding load/store controller with fixed wait states, alignment and range
// checking, little-endian lane steering and load extension.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = (MEM_BYTES > 4) ? $clog2(MEM_BYTES / 4) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  funct3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, commit, access_err;
  logic [2:0]  size;
  logic [1:0]  off;
  logic [32:0] last_byte;
  logic [3:0]  be, mem_we;
  logic [31:0] wlanes, mem_rdata, shifted, load_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = StWait;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // 33-bit sum so addresses near 2^32 cannot wrap back into range.
  always_comb begin
    size       = access_size(funct3_q);
    off        = addr_q[1:0];
    last_byte  = {1'b0, addr_q} + 33'(size) - 33'd1;
    access_err = 1'b0;
    if (!funct3_legal(funct3_q, write_q)) access_err = 1'b1;
    if ((size == 3'd2) && addr_q[0]) access_err = 1'b1;
    if ((size == 3'd4) && (off != 2'b00)) access_err = 1'b1;
    if (last_byte >= 33'(MEM_BYTES)) access_err = 1'b1;
  end

  always_comb begin
    case (size)
      3'd1: begin
        wlanes = {4{wdata_q[7:0]}};
        be     = 4'b0001 << off;
      end
      3'd2: begin
        wlanes = {2{wdata_q[15:0]}};
        be     = 4'b0011 << off;
      end
      default: begin
        wlanes = wdata_q;
        be     = 4'b1111;
      end
    endcase
    mem_we = (commit && write_q && !access_err) ? be : 4'b0000;
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    unique case (funct3_q)
      Funct3B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      Funct3Bu: load_data = {24'h0, shifted[7:0]};
      Funct3H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      Funct3Hu: load_data = {16'h0, shifted[15:0]};
      default:  load_data = shifted;
    endcase
  end

  dmem_array #(
    .MEM_BYTES(MEM_BYTES),
    .AW       (AW)
  ) u_array (
    .clk  (clk),
    .addr (addr_q[AW+1:2]),
    .we   (mem_we),
    .wdata(wlanes),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q  <= req_write;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
      end
      if (commit) begin
        err_q   <= access_err;
        rdata_q <= (access_err || write_q) ? 32'h0 : load_data;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-array reference model with timestamped commit,
// per-cycle compare, plus directed vectors carrying hand-computed results.
module tb_dmem_ctrl;

  localparam int unsigned MEM_BYTES = 4096;
  localparam int unsigned LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid, resp_ready, resp_err, busy;
  logic [31:0] resp_rdata;

  int n_chk = 0;
  int n_pass = 0;

  dmem_ctrl #(
    .MEM_BYTES(MEM_BYTES),
    .LATENCY  (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_funct3(req_funct3),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  byte unsigned mref [MEM_BYTES];
  int           m_phase = 0;  // 0 idle, 1 access in flight, 2 response pending
  longint       cyc = 0;
  longint       acc_cyc = 0;
  logic         mw = 1'b0;
  logic [31:0]  ma = 32'h0, md = 32'h0;
  logic [2:0]   mf = 3'b000;
  logic [31:0]  exp_rdata = 32'h0;
  logic         exp_err = 1'b0;

  function automatic int ref_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic ref_err(input logic w, input logic [31:0] a, input logic [2:0] f);
    int sz;
    sz = ref_size(f);
    if (sz == 0) return 1'b1;
    if (w && f[2]) return 1'b1;
    if ((int'(a[1:0]) % sz) != 0) return 1'b1;
    if (longint'({32'h0, a}) + longint'(sz) - 1 >= longint'(MEM_BYTES)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;  // any in-flight access is dropped without touching mref
    end else begin
      cyc++;
      if (m_phase == 0) begin
        if (req_valid) begin
          mw = req_write; ma = req_addr; md = req_wdata; mf = req_funct3;
          acc_cyc = cyc;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (cyc == acc_cyc + LATENCY) begin
          int     sz;
          longint v;
          sz = ref_size(mf);
          exp_err = ref_err(mw, ma, mf);
          exp_rdata = 32'h0;
          if (!exp_err && mw) begin
            for (int i = 0; i < sz; i++) mref[ma + i] = md[8*i +: 8];
          end else if (!exp_err) begin
            v = 0;
            for (int i = sz - 1; i >= 0; i--) v = v * 256 + longint'(mref[ma + i]);
            if (!mf[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
              v = v - (longint'(1) << (8 * sz));
            exp_rdata = v[31:0];
          end
          m_phase = 2;
        end
      end else if (resp_ready) begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", req_ready, 32'(m_phase == 0));
      chk("busy", busy, 32'(m_phase != 0));
      chk("resp_valid", resp_valid, 32'(m_phase == 2));
      if (m_phase == 2) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", resp_err, 32'(exp_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f, input int hold,
                        input logic [31:0] lit_rdata, input logic lit_err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    // Junk request held valid while busy must not be taken.
    req_write  = 1'b1;
    req_addr   = $urandom_range(0, MEM_BYTES - 4) & 32'hFFFF_FFFC;
    req_wdata  = $urandom;
    req_funct3 = 3'b010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    chk("latency", 32'(n), 32'(LATENCY + 1));
    chk("lit_rdata", resp_rdata, lit_rdata);
    chk("lit_err", resp_err, 32'(lit_err));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", resp_valid, 32'd1);
      chk("hold_ready", req_ready, 32'd0);
      chk("hold_rdata", resp_rdata, lit_rdata);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("idle_after_hs", busy, 32'd0);
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_funct3 = 3'b000; resp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_resp_valid", resp_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", resp_err, 32'd0);
    #8 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", req_ready, 32'd1);

    // Word store/load and sub-word extension from the same word.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, 32'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 3'b000, 0, 32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 32'h11, 32'h0, 3'b100, 0, 32'h000000BE, 1'b0);
    do_req(1'b0, 32'h12, 32'h0, 3'b101, 0, 32'h0000DEAD, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 3'b001, 0, 32'hFFFFBEEF, 1'b0);

    // Byte store at an odd address, signed and unsigned reload.
    do_req(1'b1, 32'h21, 32'hFFFFFF80, 3'b000, 0, 32'h0, 1'b0);
    do_req(1'b0, 32'h21, 32'h0, 3'b000, 0, 32'hFFFFFF80, 1'b0);
    do_req(1'b0, 32'h21, 32'h0, 3'b100, 0, 32'h00000080, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 3'b010, 0, 32'h00008000, 1'b0);

    // Misaligned halfword store leaves bytes 3 and 4 intact.
    do_req(1'b1, 32'h00, 32'hA5A5A5A5, 3'b010, 0, 32'h0, 1'b0);
    do_req(1'b1, 32'h04, 32'h5A5A5A5A, 3'b010, 0, 32'h0, 1'b0);
    do_req(1'b1, 32'h03, 32'h00001234, 3'b001, 0, 32'h0, 1'b1);
    do_req(1'b0, 32'h00, 32'h0, 3'b010, 0, 32'hA5A5A5A5, 1'b0);
    do_req(1'b0, 32'h04, 32'h0, 3'b010, 0, 32'h5A5A5A5A, 1'b0);

    // Range, alignment and encoding errors, plus in-range top-of-memory accesses.
    do_req(1'b0, MEM_BYTES - 2, 32'h0, 3'b010, 0, 32'h0, 1'b1);
    do_req(1'b0, 32'h10, 32'h0, 3'b011, 0, 32'h0, 1'b1);
    do_req(1'b0, 32'h11, 32'h0, 3'b001, 0, 32'h0, 1'b1);
    do_req(1'b0, MEM_BYTES - 4, 32'h0, 3'b010, 0, 32'h0, 1'b0);
    do_req(1'b0, MEM_BYTES - 1, 32'h0, 3'b000, 0, 32'h0, 1'b0);
    do_req(1'b0, MEM_BYTES, 32'h0, 3'b000, 0, 32'h0, 1'b1);
    do_req(1'b1, 32'hFFFF_FFFC, 32'h12345678, 3'b010, 0, 32'h0, 1'b1);
    do_req(1'b1, 32'h50, 32'h000000AA, 3'b100, 0, 32'h0, 1'b1);
    do_req(1'b0, 32'h50, 32'h0, 3'b010, 0, 32'h0, 1'b0);

    // Back-pressure: response held for five cycles.
    do_req(1'b1, 32'h30, 32'h00008001, 3'b001, 5, 32'h0, 1'b0);
    do_req(1'b0, 32'h30, 32'h0, 3'b001, 5, 32'hFFFF8001, 1'b0);
    do_req(1'b0, 32'h30, 32'h0, 3'b101, 0, 32'h00008001, 1'b0);

    // Reset during WAIT aborts the store.
    do_req(1'b1, 32'h40, 32'h11223344, 3'b010, 0, 32'h0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 32'd0);
    chk("abort_resp_valid", resp_valid, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_err", resp_err, 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 32'd0);
    end
    do_req(1'b0, 32'h40, 32'h0, 3'b010, 0, 32'h11223344, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
